// File: rtl/skolem_checker.sv
// Exhaustive checker: sweeps every x onto a candidate Skolem function and compares
// the sampled y against the relation truth table SPEC, reporting the first counterexample.
module skolem_checker #(
    parameter int                           N_IN   = 4,
    parameter logic [(1<<(N_IN+1))-1:0]     SPEC   = '1,
    parameter int                           SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] x_out,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            cex_valid,
    output logic [N_IN-1:0] cex_x,
    output logic            cex_y,
    output logic [N_IN:0]   n_cex
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          sat;
    logic          ok;
    logic [N_IN:0] n_cex_next;

    // An x for which no y satisfies the relation is a don't-care.
    always_comb begin
        sat        = SPEC[{x_out, 1'b0}] | SPEC[{x_out, 1'b1}];
        ok         = SPEC[{x_out, y_in}] | ~sat;
        n_cex_next = n_cex + {{N_IN{1'b0}}, ~ok};
    end

    assign busy = (state == S_WAIT);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            x_out     <= '0;
            pass      <= 1'b0;
            cex_valid <= 1'b0;
            cex_x     <= '0;
            cex_y     <= 1'b0;
            n_cex     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pass      <= 1'b0;
                        cex_valid <= 1'b0;
                        cex_x     <= '0;
                        cex_y     <= 1'b0;
                        n_cex     <= '0;
                        x_out     <= '0;
                        cnt       <= SETTLE_L;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        n_cex <= n_cex_next;
                        if (!ok && !cex_valid) begin
                            cex_valid <= 1'b1;
                            cex_x     <= x_out;
                            cex_y     <= y_in;
                        end
                        // pass uses the count including this final vector.
                        if (x_out == '1) begin
                            pass  <= (n_cex_next == '0);
                            state <= S_DONE;
                        end else begin
                            x_out <= x_out + 1'b1;
                            cnt   <= SETTLE_L;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_checker.sv
// Bench for skolem_checker: four instances (two SPECs, three SETTLE values) driven by
// directed runs, with expected run results queued at start and popped at done.
module tb_skolem_checker;

    localparam int N  = 4;
    localparam int NI = 4;
    localparam logic [31:0] SPEC_OK = 32'h6969_6969;
    localparam logic [31:0] SPEC_DC = 32'h6969_6909;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         start_v  [NI];
    logic         faulty_v [NI];
    logic         y_v      [NI];
    logic [N-1:0] x_v      [NI];
    logic         busy_v   [NI];
    logic         done_v   [NI];
    logic         pass_v   [NI];
    logic         cv_v     [NI];
    logic [N-1:0] cx_v     [NI];
    logic         cy_v     [NI];
    logic [N:0]   nc_v     [NI];

    logic [11:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // clock / reset
    always #5 clk = ~clk;

    // candidate functions: correct is y = x0 ^ x1, faulty is y = x0
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            y_v[i] = faulty_v[i] ? x_v[i][0] : (x_v[i][0] ^ x_v[i][1]);
        end
    end

    skolem_checker #(.N_IN(N), .SPEC(SPEC_OK), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .x_out(x_v[0]), .y_in(y_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .cex_valid(cv_v[0]),
        .cex_x(cx_v[0]), .cex_y(cy_v[0]), .n_cex(nc_v[0]));

    skolem_checker #(.N_IN(N), .SPEC(SPEC_DC), .SETTLE(1)) u_dc (
        .clk(clk), .rst(rst), .start(start_v[1]), .x_out(x_v[1]), .y_in(y_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .cex_valid(cv_v[1]),
        .cex_x(cx_v[1]), .cex_y(cy_v[1]), .n_cex(nc_v[1]));

    skolem_checker #(.N_IN(N), .SPEC(SPEC_OK), .SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start(start_v[2]), .x_out(x_v[2]), .y_in(y_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .cex_valid(cv_v[2]),
        .cex_x(cx_v[2]), .cex_y(cy_v[2]), .n_cex(nc_v[2]));

    skolem_checker #(.N_IN(N), .SPEC(SPEC_OK), .SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .x_out(x_v[3]), .y_in(y_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .cex_valid(cv_v[3]),
        .cex_x(cx_v[3]), .cex_y(cy_v[3]), .n_cex(nc_v[3]));

    function automatic int settle_of(input int i);
        case (i)
            2:       return 0;
            3:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [11:0] pack(input logic p, input logic cv, input logic [3:0] cx,
                                         input logic cy, input logic [4:0] nc);
        return {p, cv, cx, cy, nc};
    endfunction

    function automatic logic [11:0] obs_res(input int i);
        return {pass_v[i], cv_v[i], cx_v[i], cy_v[i], nc_v[i]};
    endfunction

    function automatic logic [17:0] obs_all(input int i);
        return {x_v[i], busy_v[i], done_v[i], pass_v[i], cv_v[i], cx_v[i], cy_v[i], nc_v[i]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: one-cycle start pulse, then confirm the sweep began at x=0
    task automatic start_run(input int i);
        start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        chk("start_busy", 32'(busy_v[i]), 32'd1);
        chk("start_x", 32'(x_v[i]), 32'd0);
    endtask

    // scoreboard: called just after the start edge; checks step spacing, latency, results
    task automatic wait_done(input int i);
        int cyc = 0;
        int last = 0;
        int bad = 0;
        int steps = 0;
        logic seen = 1'b0;
        logic [N-1:0] prev;
        logic [11:0] e;
        prev = x_v[i];
        while (!seen && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (x_v[i] != prev) begin
                steps++;
                if (cyc - last != settle_of(i) + 1) bad++;
                last = cyc;
                prev = x_v[i];
            end
            seen = done_v[i];
        end
        chk("done_latency", 32'(cyc), 32'(16 * (settle_of(i) + 1)));
        chk("x_steps", 32'(steps), 32'd15);
        chk("x_step_gap", 32'(bad), 32'd0);
        chk("done_busy", 32'(busy_v[i]), 32'd0);
        chk("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("run_result", 32'(obs_res(i)), 32'(e));
        end
    endtask

    initial begin
        int k;
        for (int i = 0; i < NI; i++) begin
            start_v[i]  = 1'b0;
            faulty_v[i] = 1'b0;
        end

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk("reset_outputs", 32'(obs_all(i)), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // correct candidate
        exp_q.push_back(pack(1'b1, 1'b0, 4'd0, 1'b0, 5'd0));
        start_run(0);
        wait_done(0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_done_low", 32'(done_v[0]), 32'd0);
        chk("idle_hold", 32'(obs_res(0)), 32'(pack(1'b1, 1'b0, 4'd0, 1'b0, 5'd0)));

        // faulty candidate
        faulty_v[0] = 1'b1;
        exp_q.push_back(pack(1'b0, 1'b1, 4'd2, 1'b0, 5'd8));
        start_run(0);
        wait_done(0);
        @(posedge clk); #1;

        // don't-care x=2,3 removed from the relation
        faulty_v[1] = 1'b1;
        exp_q.push_back(pack(1'b0, 1'b1, 4'd6, 1'b0, 5'd6));
        start_run(1);
        wait_done(1);
        @(posedge clk); #1;

        // settle timing
        exp_q.push_back(pack(1'b1, 1'b0, 4'd0, 1'b0, 5'd0));
        start_run(2);
        wait_done(2);
        exp_q.push_back(pack(1'b1, 1'b0, 4'd0, 1'b0, 5'd0));
        start_run(3);
        wait_done(3);
        @(posedge clk); #1;

        // start held high: no restart while busy, next run clears the old results
        faulty_v[0] = 1'b1;
        exp_q.push_back(pack(1'b0, 1'b1, 4'd2, 1'b0, 5'd8));
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        wait_done(0);
        faulty_v[0] = 1'b0;
        exp_q.push_back(pack(1'b1, 1'b0, 4'd0, 1'b0, 5'd0));
        @(posedge clk); #1;
        chk("restart_idle_busy", 32'({busy_v[0], done_v[0]}), 32'd0);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        chk("restart_busy", 32'(busy_v[0]), 32'd1);
        chk("restart_x", 32'(x_v[0]), 32'd0);
        chk("restart_cleared", 32'(obs_res(0)), 32'd0);
        wait_done(0);
        @(posedge clk); #1;

        // reset mid-run with an accumulated counterexample
        faulty_v[0] = 1'b1;
        start_run(0);
        k = 0;
        while (x_v[0] != 4'd7 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_x7", 32'(x_v[0]), 32'd7);
        chk("mid_cex", 32'({cv_v[0], cx_v[0], nc_v[0]}), 32'({1'b1, 4'd2, 5'd3}));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_reset", 32'(obs_all(0)), 32'd0);
        exp_q.push_back(pack(1'b0, 1'b1, 4'd2, 1'b0, 5'd8));
        start_run(0);
        wait_done(0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/skolem_checker.md
# skolem_checker

Sequential exhaustive verifier for single-output combinational Skolem functions. It drives every input assignment onto a candidate function under test and samples the function's output. Each (x, y) pair is checked against a specification relation F(x, y) held as a truth-table parameter, and the block reports pass/fail, the first counterexample and the counterexample count. It sits at the input/output boundary of a generated SKOLEMFORMULA-style module: it drives the inputs and reads the output.

## Interface
- N_IN, 4, number of Skolem inputs; legal range 1..8.
- SPEC, all ones, relation truth table, width 2^(N_IN+1); bit index {x, y} (x in the MSBs, y in the LSB); 1 means F(x, y) holds.
- SETTLE, 1, wait cycles between driving x and sampling y; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a check run when sampled high in IDLE.
- x_out  out  N_IN  assignment driven to the function under test.
- y_in  in  1  output of the function under test (combinational).
- busy  out  1  high while vectors are being applied.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 when the last completed run found no counterexample.
- cex_valid  out  1  a counterexample was found in the last run.
- cex_x  out  N_IN  x of the first counterexample.
- cex_y  out  1  y of the first counterexample.
- n_cex  out  N_IN+1  number of counterexamples in the run.

## Operation
- States: IDLE, WAIT, DONE.
- Reset (rst=1 at an edge) forces IDLE and sets every output to 0: x_out, busy, done, pass, cex_valid, cex_x, cex_y, n_cex. This applies in any state and aborts any run in progress.
- IDLE, start=1:
  - Clear pass, cex_valid, cex_x, cex_y and n_cex.
  - Set x_out=0 and settle counter=SETTLE, then go to WAIT.
- IDLE, start=0: hold all outputs, including the previous run's results.
- WAIT, counter≠0: decrement the counter.
- WAIT, counter=0: sample y_in and evaluate:
  - sat = SPEC[{x_out,1'b0}] | SPEC[{x_out,1'b1}]
  - ok = SPEC[{x_out,y_in}] | ~sat
  - An x with no satisfying y is don't-care and is never a counterexample.
- On ok=0:
  - Increment n_cex.
  - If cex_valid=0, latch cex_x=x_out and cex_y=y_in, and set cex_valid=1.
  - n_cex is at most 2^N_IN and needs no saturation.
- After evaluation in WAIT:
  - If x_out=all ones, go to DONE; x_out holds.
  - Otherwise increment x_out, reload the counter with SETTLE and stay in WAIT.
- DONE: done=1 and pass=(n_cex==0), using the final n_cex including the last vector; go to IDLE on the next edge.
- start is ignored in WAIT and DONE.
- Only start=1 in IDLE begins a run.

## Timing
- busy=1 exactly while in WAIT.
- For start sampled at edge k:
  - busy rises after edge k.
  - Each vector occupies SETTLE+1 cycles.
  - done is high during cycle k+1+2^N_IN·(SETTLE+1), with busy=0.
- x_out is registered.
  - y_in must settle within SETTLE cycles plus the same-cycle path.
  - With SETTLE=0, y_in is sampled in the same cycle x_out is valid.
- pass, cex_valid and n_cex are valid from the done cycle until the next start or rst.
- cex_x and cex_y are valid only while cex_valid=1.
- A start one cycle after done (back in IDLE) is accepted.

## Test plan
- **Correct candidate.** N_IN=4, SETTLE=1, SPEC satisfied exactly by y=x0^x1 (bit 2x+(x0^x1) set, all other bits 0); bench drives y_in=x_out[0]^x_out[1].
  - Expect done at cycle k+33 and pass=1.
  - Expect n_cex=0 and cex_valid=0.
- **Faulty candidate.** Same SPEC; y_in=x_out[0].
  - Expect n_cex=8 (x = 2,3,6,7,10,11,14,15) and pass=0.
  - Expect cex_valid=1, cex_x=2, cex_y=0.
- **Don't-care.** Same faulty bench; additionally clear both SPEC bits for x=2 and x=3.
  - Expect n_cex=6, cex_x=6, cex_y=0.
- **Settle timing.** SETTLE=0, then SETTLE=3, correct candidate.
  - Expect done at k+17 and k+65 respectively.
  - Expect x_out to change every 1 and every 4 cycles respectively.
- **Start and restart.**
  - start held high throughout a run: no restart while busy; a new run begins the cycle after done.
  - Outputs clear on restart.
- **Reset mid-run.** rst pulsed while x_out=7 with an accumulated counterexample.
  - Next cycle: IDLE, all outputs 0.
  - A subsequent start runs from x_out=0.
